ef9345_cmd_seq: RTL and testbench

Command sequencer for the EF9345 video block. It executes the indirect command written to R0 against the single-port video RAM, using the R1 data register and the R6/R7 pointer registers. Video RAM is shared with the display fetch path, and display fetch always has priority. The block sits between the host register file and the VRAM port, and it drives the busy status bit read back through R0.

---
 rtl/ef9345_cmd_seq.sv | 134 +++++++++++++
 tb/tb_ef9345_cmd_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ef9345_cmd_seq.sv
// EF9345 indirect command sequencer: runs the R0 command (NOP/WRITE/READ/FILL)
// against single-port VRAM, yielding to display fetch whenever it requests.
//
// Ports:
//   clk_in, reset_       clock, async active-low reset
//   cmd_valid, cmd       R0 execute pulse and value ([7:4] opcode, [0] auto-inc)
//   r1_in, r6_in, r7_in  data, row and column registers at command start
//   busy                 command in progress (R0 bit 7)
//   r1_out, r1_load      READ result and its load strobe
//   r7_out, r7_load      updated column pointer and its load strobe
//   disp_req, disp_addr  display fetch request/address (has priority)
//   vram_*               VRAM port; rdata valid one cycle after address
module ef9345_cmd_seq #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk_in,
    input  logic          reset_,
    input  logic          cmd_valid,
    input  logic [7:0]    cmd,
    input  logic [DW-1:0] r1_in,
    input  logic [7:0]    r6_in,
    input  logic [7:0]    r7_in,
    output logic          busy,
    output logic [DW-1:0] r1_out,
    output logic          r1_load,
    output logic [7:0]    r7_out,
    output logic          r7_load,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [AW-1:0] vram_addr,
    output logic [DW-1:0] vram_wdata,
    output logic          vram_we,
    input  logic [DW-1:0] vram_rdata
);

    typedef enum logic [2:0] {
        IDLE, EXEC, WR, RA, RD, FL, DONE
    } state_t;

    state_t        state;
    logic [3:0]    op;
    logic          inc;
    logic [DW-1:0] data;
    logic [AW-9:0] row;
    logic [7:0]    x;

    // Opcode bits [3:1] and the upper row bits have no function here.
    logic unused_bits;
    assign unused_bits = ^{cmd[3:1], r6_in[7:AW-8]};

    // Display fetch wins the port in the same cycle it asks for it, so the
    // write enable must be gated combinationally rather than registered.
    assign vram_addr  = disp_req ? disp_addr : {row, x};
    assign vram_we    = !disp_req && (state == WR || state == FL);
    assign vram_wdata = data;

    always_ff @(posedge clk_in or negedge reset_) begin
        if (!reset_) begin
            state   <= IDLE;
            op      <= '0;
            inc     <= 1'b0;
            data    <= '0;
            row     <= '0;
            x       <= '0;
            busy    <= 1'b0;
            r1_out  <= '0;
            r1_load <= 1'b0;
            r7_out  <= '0;
            r7_load <= 1'b0;
        end else begin
            r1_load <= 1'b0;
            r7_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op    <= cmd[7:4];
                        inc   <= cmd[0];
                        data  <= r1_in;
                        row   <= r6_in[AW-9:0];
                        x     <= r7_in;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (op)
                        4'h1:    state <= WR;
                        4'h2:    state <= RA;
                        4'h3:    state <= FL;
                        default: state <= DONE;
                    endcase
                end
                WR: begin
                    if (!disp_req) begin
                        if (inc) begin
                            r7_out  <= x + 8'd1;
                            r7_load <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                RA: begin
                    if (!disp_req) state <= RD;
                end
                RD: begin
                    r1_out  <= vram_rdata;
                    r1_load <= 1'b1;
                    if (inc) begin
                        r7_out  <= x + 8'd1;
                        r7_load <= 1'b1;
                    end
                    state <= DONE;
                end
                FL: begin
                    if (!disp_req) begin
                        x <= x + 8'd1;
                        if (x == 8'hFF) begin
                            r7_out  <= 8'h00;
                            r7_load <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ef9345_cmd_seq.sv
// Directed self-checking bench for ef9345_cmd_seq with a behavioural VRAM.
// A negedge monitor tallies busy cycles, writes and load strobes.
module tb_ef9345_cmd_seq;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk_in = 1'b0;
    logic          reset_;
    logic          cmd_valid;
    logic [7:0]    cmd;
    logic [DW-1:0] r1_in;
    logic [7:0]    r6_in;
    logic [7:0]    r7_in;
    logic          busy;
    logic [DW-1:0] r1_out;
    logic          r1_load;
    logic [7:0]    r7_out;
    logic          r7_load;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_wdata;
    logic          vram_we;
    logic [DW-1:0] vram_rdata;

    ef9345_cmd_seq #(.AW(AW), .DW(DW)) dut (
        .clk_in(clk_in), .reset_(reset_),
        .cmd_valid(cmd_valid), .cmd(cmd),
        .r1_in(r1_in), .r6_in(r6_in), .r7_in(r7_in),
        .busy(busy),
        .r1_out(r1_out), .r1_load(r1_load),
        .r7_out(r7_out), .r7_load(r7_load),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_we(vram_we), .vram_rdata(vram_rdata)
    );

    always #5 clk_in = ~clk_in;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk_in) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    int n_busy, n_we, n_we_disp, n_r1, n_r7;
    logic [AW-1:0] first_addr, last_addr;
    logic [DW-1:0] last_data, r1_seen;
    logic [7:0]    r7_seen;

    always @(negedge clk_in) begin
        if (busy) n_busy++;
        if (vram_we) begin
            if (n_we == 0) first_addr = vram_addr;
            n_we++;
            last_addr = vram_addr;
            last_data = vram_wdata;
            if (disp_req) n_we_disp++;
        end
        if (r1_load) begin n_r1++; r1_seen = r1_out; end
        if (r7_load) begin n_r7++; r7_seen = r7_out; end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_busy = 0; n_we = 0; n_we_disp = 0; n_r1 = 0; n_r7 = 0;
        first_addr = '0; last_addr = '0; last_data = '0;
        r1_seen = '0; r7_seen = '0;
    endtask

    task automatic run(input logic [7:0] c, input logic [7:0] d,
                       input logic [7:0] r6v, input logic [7:0] r7v,
                       input int stall);
        clr();
        cmd = c; r1_in = d; r6_in = r6v; r7_in = r7v;
        cmd_valid = 1'b1;
        @(posedge clk_in); #1;
        cmd_valid = 1'b0;
        if (stall > 0) begin
            @(posedge clk_in); #1;
            disp_req  = 1'b1;
            disp_addr = 14'h3FFF;
            repeat (stall) begin @(posedge clk_in); #1; end
            disp_req = 1'b0;
        end
        for (int i = 0; i < 400 && busy; i++) begin
            @(posedge clk_in); #1;
        end
        chk("timeout", busy, 1'b0);
        repeat (2) begin @(posedge clk_in); #1; end
    endtask

    int saved;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[14'h0305] = 8'hC3;
        reset_ = 1'b0; cmd_valid = 1'b0; cmd = '0;
        r1_in = '0; r6_in = '0; r7_in = '0;
        disp_req = 1'b1; disp_addr = 14'h1234;
        clr();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_r1_load", r1_load, 0);
        chk("rst_r7_load", r7_load, 0);
        chk("rst_we", vram_we, 0);
        chk("rst_r1_out", r1_out, 0);
        chk("rst_r7_out", r7_out, 0);
        chk("rst_wdata", vram_wdata, 0);
        chk("rst_disp_addr", vram_addr, 14'h1234);
        reset_ = 1'b1;
        disp_req = 1'b0;
        repeat (2) begin @(posedge clk_in); #1; end

        run(8'h11, 8'h5A, 8'h02, 8'h10, 0);
        chk("wr_count", n_we, 1);
        chk("wr_addr", last_addr, 14'h0210);
        chk("wr_data", last_data, 8'h5A);
        chk("wr_r7_load", n_r7, 1);
        chk("wr_r7_out", r7_seen, 8'h11);
        chk("wr_busy", n_busy, 3);

        run(8'h20, 8'h00, 8'h03, 8'h05, 0);
        chk("rd_r1_load", n_r1, 1);
        chk("rd_r1_out", r1_seen, 8'hC3);
        chk("rd_r7_load", n_r7, 0);
        chk("rd_busy", n_busy, 4);
        chk("rd_no_we", n_we, 0);

        run(8'h10, 8'h77, 8'h05, 8'h20, 3);
        chk("st_we_disp", n_we_disp, 0);
        chk("st_count", n_we, 1);
        chk("st_addr", last_addr, 14'h0520);
        chk("st_mem", mem[14'h0520], 8'h77);
        chk("st_busy", n_busy, 6);

        run(8'h30, 8'hAA, 8'h01, 8'hFC, 0);
        chk("fl_count", n_we, 4);
        chk("fl_first", first_addr, 14'h01FC);
        chk("fl_last", last_addr, 14'h01FF);
        chk("fl_no_0200", mem[14'h0200], 8'h00);
        chk("fl_mem_1fd", mem[14'h01FD], 8'hAA);
        chk("fl_r7_load", n_r7, 1);
        chk("fl_r7_out", r7_seen, 8'h00);
        chk("fl_busy", n_busy, 6);

        run(8'h11, 8'h12, 8'h04, 8'hFF, 0);
        chk("wrap_addr", last_addr, 14'h04FF);
        chk("wrap_r7_load", n_r7, 1);
        chk("wrap_r7_out", r7_seen, 8'h00);

        clr();
        cmd = 8'h31; r1_in = 8'h55; r6_in = 8'h10; r7_in = 8'h00;
        cmd_valid = 1'b1;
        @(posedge clk_in); #1;
        cmd_valid = 1'b0;
        repeat (5) begin @(posedge clk_in); #1; end
        cmd = 8'h11; r1_in = 8'h99; r6_in = 8'h3F; r7_in = 8'h00;
        cmd_valid = 1'b1;
        @(posedge clk_in); #1;
        cmd_valid = 1'b0;
        repeat (3) begin @(posedge clk_in); #1; end
        chk("mf_busy_before", busy, 1);
        @(posedge clk_in); #3;
        reset_ = 1'b0;
        #1;
        chk("mf_busy_async", busy, 0);
        chk("mf_we_async", vram_we, 0);
        chk("mf_writes", n_we, 9);
        saved = n_we;
        repeat (3) @(posedge clk_in);
        #1;
        reset_ = 1'b1;
        repeat (4) begin @(posedge clk_in); #1; end
        chk("mf_no_more_we", n_we, saved);
        chk("mf_busy_after", busy, 0);
        chk("mf_last_written", mem[14'h1008], 8'h55);
        chk("mf_not_written", mem[14'h1009], 8'h00);
        chk("mf_ignored_cmd", mem[14'h3F00], 8'h00);

        run(8'h70, 8'h66, 8'h07, 8'h07, 0);
        chk("il_busy", n_busy, 2);
        chk("il_no_we", n_we, 0);
        chk("il_r1_load", n_r1, 0);
        chk("il_r7_load", n_r7, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
